sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, number of independent sprites (1..8).
REQ-002 SHALL have parameter SPRITE_W, default 32, sprite width in pixels.
REQ-003 SHALL have parameter SPRITE_H, default 32, sprite height in pixels.
REQ-004 SHALL have parameter COORD_W, default 10, coordinate width.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port frameStart  input  1  one-cycle pulse, asserted in vertical blanking.
REQ-008 SHALL have port bright  input  1  visible-area flag.
REQ-009 SHALL have ports hCount, vCount  input  COORD_W each  current pixel coordinates.
REQ-010 SHALL have port spritePos  input  NUM_SPRITES*2*COORD_W  per sprite i: {x,y}, x in upper half; y is the bottom row.
REQ-011 SHALL have port spriteEn  input  NUM_SPRITES  per-sprite enable.
REQ-012 SHALL have port spriteColor  input  NUM_SPRITES*12  per-sprite 12-bit RGB.
REQ-013 SHALL have port blockType  input  3  tile class at the current pixel.
REQ-014 SHALL have port rgb  output  12  registered pixel colour.
REQ-015 SHALL have port collisionFlags  output  NUM_SPRITES  per-sprite block-contact flags from the last completed frame.

Function
REQ-016 SHALL latch spritePos, spriteEn and spriteColor into shadow registers only in a cycle with frameStart=1; shadow values stay constant for the rest of the frame.
REQ-017 SHALL treat sprite i as covering a pixel when enabled and x <= hCount < x+SPRITE_W and y-SPRITE_H < vCount <= y.
REQ-018 SHALL compute these bounds at COORD_W+1 bits with no wrap-around: the right edge past 2^COORD_W-1 clips, and y < SPRITE_H-1 clips the top at row 0.
REQ-019 SHALL run a 2-stage pipeline. Stage 1 registers the per-sprite hit vector, blockType and bright. Stage 2 registers rgb. The rgb for inputs at cycle N SHALL appear at cycle N+2.
REQ-020 SHALL resolve overlap by fixed priority, with the lowest set index winning.
REQ-021 SHALL select rgb in this order:
  - bright low: 12'h000
  - any sprite hit: that sprite's colour
  - blockType 0: 12'hF00
  - blockType 1: 12'h00F
  - other: 12'hCCC
REQ-022 SHALL OR into an accumulator, every stage-1 cycle with bright=1 and blockType != 0, the hit vector of all covering sprites, regardless of priority.
REQ-023 SHALL on frameStart copy the accumulator (including that cycle's stage-1 contribution) to collisionFlags and clear the accumulator in the same cycle.
REQ-024 SHALL hold collisionFlags stable between frameStart pulses.
REQ-025 SHALL treat back-to-back frameStart pulses each as a frame boundary, so a second pulse publishes an empty accumulator.

Reset
REQ-026 SHALL on rst=1 clear rgb, collisionFlags, the accumulator, all shadow registers (spriteEn=0) and the pipeline registers to zero.
REQ-027 SHALL let rst win over a simultaneous frameStart, so no shadow latch or publish occurs that cycle.
REQ-028 SHALL after a mid-frame reset draw no sprites and flag no collisions until the next frameStart.

Structure
REQ-029 SHALL place the colour constants (BLACK, block colours) and blockType codes in the shared display package.
REQ-030 SHALL use one sub-module, sprite_hit_test (one instance per sprite), holding the shadow registers and the bounds compare for one sprite.

Verification
REQ-031 SHALL cover: sprite0 {x=100,y=200}, enabled, frameStart -> rgb=colour0 for hCount 100..131, vCount 169..200, 2 cycles after input; hCount 132 -> background.
REQ-032 SHALL cover: sprites 0 and 2 overlapping at (150,150) -> rgb=colour0; disable sprite0 at next frameStart -> colour2.
REQ-033 SHALL cover: sprite1 placed over blockType=2 pixels with bright=1 -> collisionFlags=4'b0010 after the next frameStart and 4'b0000 after the one after that with no contact.
REQ-034 SHALL cover: spritePos changed mid-frame -> displayed position unchanged until frameStart.
REQ-035 SHALL cover: sprite at x=1010, y=10 -> clipped drawing with no wrap to column 0 or row 1023.
REQ-036 SHALL cover: rst asserted mid-frame together with frameStart -> rgb=0 next cycle, collisionFlags=0, no sprites until the following frameStart.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared display package: colour constants, block-type codes and background lookup.
package sprite_compositor_pkg;

  localparam int unsigned RGB_W        = 12;
  localparam int unsigned BLOCK_TYPE_W = 3;

  localparam logic [RGB_W-1:0] BLACK        = 12'h000;
  localparam logic [RGB_W-1:0] BLOCK0_COLOR = 12'hF00;
  localparam logic [RGB_W-1:0] BLOCK1_COLOR = 12'h00F;
  localparam logic [RGB_W-1:0] OTHER_COLOR  = 12'hCCC;

  localparam logic [BLOCK_TYPE_W-1:0] BLK_TYPE0 = 3'd0;
  localparam logic [BLOCK_TYPE_W-1:0] BLK_TYPE1 = 3'd1;

  function automatic logic [RGB_W-1:0] blockColor(input logic [BLOCK_TYPE_W-1:0] blk);
    logic [RGB_W-1:0] c;
    c = OTHER_COLOR;
    if (blk == BLK_TYPE0) begin
      c = BLOCK0_COLOR;
    end else if (blk == BLK_TYPE1) begin
      c = BLOCK1_COLOR;
    end
    return c;
  endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// One sprite: frame-stable shadow registers plus the pixel-in-bounds compare.
module sprite_hit_test
  import sprite_compositor_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int COORD_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frameStart,
  input  logic [COORD_W-1:0]   hCount,
  input  logic [COORD_W-1:0]   vCount,
  input  logic [2*COORD_W-1:0] posIn,
  input  logic                 enIn,
  input  logic [RGB_W-1:0]     colorIn,
  output logic                 hit,
  output logic [RGB_W-1:0]     color
);

  localparam logic [COORD_W:0] WExt = (COORD_W + 1)'(SPRITE_W);
  localparam logic [COORD_W:0] HExt = (COORD_W + 1)'(SPRITE_H);

  logic [COORD_W-1:0] xQ;
  logic [COORD_W-1:0] yQ;
  logic               enQ;
  logic [RGB_W-1:0]   colorQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      xQ     <= '0;
      yQ     <= '0;
      enQ    <= 1'b0;
      colorQ <= '0;
    end else if (frameStart) begin
      xQ     <= posIn[2*COORD_W-1:COORD_W];
      yQ     <= posIn[COORD_W-1:0];
      enQ    <= enIn;
      colorQ <= colorIn;
    end
  end

  // One extra bit so x+W never wraps; the top test is rewritten as v+H > y to avoid y-H underflow.
  logic [COORD_W:0] xRight;
  logic [COORD_W:0] vPlusH;

  always_comb begin
    xRight = {1'b0, xQ} + WExt;
    vPlusH = {1'b0, vCount} + HExt;
    hit    = enQ
           && (hCount >= xQ) && ({1'b0, hCount} < xRight)
           && (vCount <= yQ) && (vPlusH > {1'b0, yQ});
  end

  assign color = colorQ;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor with fixed-priority overlap and per-frame block collision flags.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int COORD_W     = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frameStart,
  input  logic                           bright,
  input  logic [COORD_W-1:0]             hCount,
  input  logic [COORD_W-1:0]             vCount,
  input  logic [NUM_SPRITES*2*COORD_W-1:0] spritePos,
  input  logic [NUM_SPRITES-1:0]         spriteEn,
  input  logic [NUM_SPRITES*RGB_W-1:0]   spriteColor,
  input  logic [BLOCK_TYPE_W-1:0]        blockType,
  output logic [RGB_W-1:0]               rgb,
  output logic [NUM_SPRITES-1:0]         collisionFlags
);

  logic [NUM_SPRITES-1:0] hitVec;
  logic [RGB_W-1:0]       sprColor [NUM_SPRITES];

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : gSprite
    sprite_hit_test #(
      .SPRITE_W(SPRITE_W),
      .SPRITE_H(SPRITE_H),
      .COORD_W (COORD_W)
    ) uHit (
      .clk       (clk),
      .rst       (rst),
      .frameStart(frameStart),
      .hCount    (hCount),
      .vCount    (vCount),
      .posIn     (spritePos[i*2*COORD_W +: 2*COORD_W]),
      .enIn      (spriteEn[i]),
      .colorIn   (spriteColor[i*RGB_W +: RGB_W]),
      .hit       (hitVec[i]),
      .color     (sprColor[i])
    );
  end

  // Stage 1
  logic [NUM_SPRITES-1:0]  hitQ;
  logic [BLOCK_TYPE_W-1:0] blockQ;
  logic                    brightQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      hitQ    <= '0;
      blockQ  <= '0;
      brightQ <= 1'b0;
    end else begin
      hitQ    <= hitVec;
      blockQ  <= blockType;
      brightQ <= bright;
    end
  end

  // Every covering sprite counts as contact, not only the one that wins the colour.
  logic [NUM_SPRITES-1:0] contact;
  logic [NUM_SPRITES-1:0] accumQ;

  assign contact = (brightQ && (blockQ != BLK_TYPE0)) ? hitQ : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      accumQ         <= '0;
      collisionFlags <= '0;
    end else if (frameStart) begin
      collisionFlags <= accumQ | contact;
      accumQ         <= '0;
    end else begin
      accumQ <= accumQ | contact;
    end
  end

  // Stage 2
  logic [RGB_W-1:0] rgbD;

  always_comb begin
    rgbD = BLACK;
    if (brightQ) begin
      rgbD = blockColor(blockQ);
      // Descending scan so the lowest hitting index is assigned last and wins.
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
        if (hitQ[i]) begin
          rgbD = sprColor[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= BLACK;
    end else begin
      rgb <= rgbD;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized and directed bench for sprite_compositor against a rule-level reference model.
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int SW = 32;
  localparam int SH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              frameStart;
  logic              bright;
  logic [CW-1:0]     hCount;
  logic [CW-1:0]     vCount;
  logic [N*2*CW-1:0] spritePos;
  logic [N-1:0]      spriteEn;
  logic [N*12-1:0]   spriteColor;
  logic [2:0]        blockType;
  logic [11:0]       rgb;
  logic [N-1:0]      collisionFlags;

  always #5 clk = ~clk;

  sprite_compositor #(
    .NUM_SPRITES(N),
    .SPRITE_W   (SW),
    .SPRITE_H   (SH),
    .COORD_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frameStart    (frameStart),
    .bright        (bright),
    .hCount        (hCount),
    .vCount        (vCount),
    .spritePos     (spritePos),
    .spriteEn      (spriteEn),
    .spriteColor   (spriteColor),
    .blockType     (blockType),
    .rgb           (rgb),
    .collisionFlags(collisionFlags)
  );

  // Reference model state: the frame's sprite set, collision accumulation, 2-cycle pixel delay.
  int          mX [N];
  int          mY [N];
  bit          mEn[N];
  logic [11:0] mCol[N];
  logic [N-1:0] accum, flags, pend;
  logic [11:0] d1, rgbExp;
  int          checks = 0;
  int          passed = 0;

  function automatic bit covers(int i, int h, int v);
    return mEn[i] && h >= mX[i] && h < mX[i] + SW && v <= mY[i] && v > mY[i] - SH;
  endfunction

  function automatic logic [11:0] pixColour(int h, int v, bit br, int blk);
    if (!br) return 12'h000;
    for (int i = 0; i < N; i++) if (covers(i, h, v)) return mCol[i];
    if (blk == 0) return 12'hF00;
    if (blk == 1) return 12'h00F;
    return 12'hCCC;
  endfunction

  function automatic logic [N-1:0] contactOf(int h, int v, bit br, int blk);
    logic [N-1:0] c = '0;
    if (br && blk != 0) for (int i = 0; i < N; i++) c[i] = covers(i, h, v);
    return c;
  endfunction

  task automatic step();
    logic [N-1:0] cur;
    logic [11:0]  px;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mX[i] = 0; mY[i] = 0; mEn[i] = 1'b0; mCol[i] = '0;
      end
      accum = '0; flags = '0; pend = '0; d1 = '0; rgbExp = '0;
    end else begin
      cur = contactOf(int'(hCount), int'(vCount), bright, int'(blockType));
      px  = pixColour(int'(hCount), int'(vCount), bright, int'(blockType));
      if (frameStart) begin
        flags = accum | pend;
        accum = '0;
      end else begin
        accum = accum | pend;
      end
      pend   = cur;
      rgbExp = d1;
      d1     = px;
      if (frameStart) begin
        for (int i = 0; i < N; i++) begin
          mX[i]   = int'(spritePos[i*2*CW+CW +: CW]);
          mY[i]   = int'(spritePos[i*2*CW +: CW]);
          mEn[i]  = spriteEn[i];
          mCol[i] = spriteColor[i*12 +: 12];
        end
      end
    end
    #1;
  endtask

  task automatic setSprite(int i, int x, int y, bit en, logic [11:0] c);
    spritePos[i*2*CW +: 2*CW] = {x[CW-1:0], y[CW-1:0]};
    spriteEn[i]               = en;
    spriteColor[i*12 +: 12]   = c;
  endtask

  task automatic pix(int h, int v, bit br, int blk);
    hCount    = h[CW-1:0];
    vCount    = v[CW-1:0];
    bright    = br;
    blockType = blk[2:0];
  endtask

  task automatic frame();
    frameStart = 1'b1;
    bright     = 1'b0;
    step();
    frameStart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frameStart = 1'b0; spritePos = '0; spriteEn = '0; spriteColor = '0;
    pix(0, 0, 0, 0);
    step(); step();
    checks++;
    if (rgb !== 12'h000) $display("FAIL reset_rgb got %h want 000", rgb); else passed++;
    checks++;
    if (collisionFlags !== '0) $display("FAIL reset_flags got %b want 0000", collisionFlags);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int hs[4] = '{99, 100, 131, 132};
    int vs[4] = '{168, 169, 200, 201};
    setSprite(0, 100, 200, 1, 12'hA5A);
    for (int i = 1; i < N; i++) setSprite(i, 0, 0, 0, 12'h000);
    frame();
    foreach (hs[a]) foreach (vs[b]) begin
      pix(hs[a], vs[b], 1, 2);
      step(); step();
      checks++;
      if (rgb !== rgbExp) $display("FAIL basic h=%0d v=%0d got %h want %h", hs[a], vs[b], rgb, rgbExp);
      else passed++;
    end
    pix(100, 169, 1, 0); step(); step();
    checks++;
    if (rgb !== 12'hA5A) $display("FAIL basic_corner got %h want a5a", rgb); else passed++;
    pix(132, 180, 1, 2); step(); step();
    checks++;
    if (rgb !== 12'hCCC) $display("FAIL basic_right_edge got %h want ccc", rgb); else passed++;
  endtask

  task automatic test_priority();
    setSprite(0, 140, 160, 1, 12'h111);
    setSprite(2, 130, 170, 1, 12'h222);
    frame();
    pix(150, 150, 1, 1); step(); step();
    checks++;
    if (rgb !== 12'h111) $display("FAIL priority_low got %h want 111", rgb); else passed++;
    setSprite(0, 140, 160, 0, 12'h111);
    frame();
    pix(150, 150, 1, 1); step(); step();
    checks++;
    if (rgb !== 12'h222) $display("FAIL priority_next got %h want 222", rgb); else passed++;
  endtask

  task automatic test_collision();
    for (int i = 0; i < N; i++) setSprite(i, 0, 0, 0, 12'h000);
    setSprite(1, 300, 300, 1, 12'h0F0);
    frame(); frame();
    pix(310, 290, 1, 2); step(); step(); step();
    pix(0, 0, 0, 0); step();
    frame();
    checks++;
    if (collisionFlags !== 4'b0010) $display("FAIL coll_set got %b want 0010", collisionFlags);
    else passed++;
    pix(310, 290, 1, 0); step(); step(); step();
    frame();
    checks++;
    if (collisionFlags !== 4'b0000) $display("FAIL coll_clear got %b want 0000", collisionFlags);
    else passed++;
    // Contact right up to the boundary, then two pulses in a row.
    pix(310, 290, 1, 3); step(); step();
    frameStart = 1'b1; bright = 1'b0;
    step();
    checks++;
    if (collisionFlags !== 4'b0010) $display("FAIL coll_b2b_first got %b want 0010", collisionFlags);
    else passed++;
    step();
    frameStart = 1'b0;
    checks++;
    if (collisionFlags !== 4'b0000) $display("FAIL coll_b2b_second got %b want 0000", collisionFlags);
    else passed++;
    checks++;
    if (collisionFlags !== flags) $display("FAIL coll_model got %b want %b", collisionFlags, flags);
    else passed++;
  endtask

  task automatic test_midframe();
    setSprite(3, 500, 500, 1, 12'h333);
    frame();
    pix(510, 490, 1, 1); step(); step();
    checks++;
    if (rgb !== 12'h333) $display("FAIL mid_before got %h want 333", rgb); else passed++;
    setSprite(3, 600, 600, 1, 12'h333);
    step(); step();
    checks++;
    if (rgb !== 12'h333) $display("FAIL mid_old_pos got %h want 333", rgb); else passed++;
    pix(610, 590, 1, 1); step(); step();
    checks++;
    if (rgb !== 12'h00F) $display("FAIL mid_new_pos_early got %h want 00f", rgb); else passed++;
    frame();
    pix(610, 590, 1, 1); step(); step();
    checks++;
    if (rgb !== 12'h333) $display("FAIL mid_new_pos got %h want 333", rgb); else passed++;
  endtask

  task automatic test_clip();
    int          ph[7] = '{1023, 1010, 0, 1015, 5, 1009, 1015};
    int          pv[7] = '{10, 0, 10, 1023, 5, 10, 11};
    logic [11:0] pe[7];
    pe = '{12'h444, 12'h444, 12'hCCC, 12'hCCC, 12'hCCC, 12'hCCC, 12'hCCC};
    for (int i = 0; i < N; i++) setSprite(i, 0, 0, 0, 12'h000);
    setSprite(0, 1010, 10, 1, 12'h444);
    frame();
    foreach (ph[k]) begin
      pix(ph[k], pv[k], 1, 2); step(); step();
      checks++;
      if (rgb !== pe[k]) $display("FAIL clip h=%0d v=%0d got %h want %h", ph[k], pv[k], rgb, pe[k]);
      else passed++;
      checks++;
      if (rgb !== rgbExp) $display("FAIL clip_model h=%0d got %h want %h", ph[k], rgb, rgbExp);
      else passed++;
    end
  endtask

  task automatic test_rst_frame();
    for (int i = 0; i < N; i++) setSprite(i, 0, 0, 0, 12'h000);
    setSprite(0, 100, 100, 1, 12'h555);
    frame();
    pix(105, 90, 1, 2); step(); step(); step();
    rst = 1'b1; frameStart = 1'b1;
    step();
    checks++;
    if (rgb !== 12'h000) $display("FAIL rstfs_rgb got %h want 000", rgb); else passed++;
    checks++;
    if (collisionFlags !== 4'b0000) $display("FAIL rstfs_flags got %b want 0000", collisionFlags);
    else passed++;
    rst = 1'b0; frameStart = 1'b0;
    step(); step();
    checks++;
    if (rgb !== 12'hCCC) $display("FAIL rstfs_nosprite got %h want ccc", rgb); else passed++;
    step();
    frame();
    checks++;
    if (collisionFlags !== 4'b0000) $display("FAIL rstfs_nocoll got %b want 0000", collisionFlags);
    else passed++;
    pix(105, 90, 1, 2); step(); step();
    checks++;
    if (rgb !== 12'h555) $display("FAIL rstfs_resume got %h want 555", rgb); else passed++;
  endtask

  task automatic test_random();
    int j, x, y;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 29) == 0) begin
        for (int i = 0; i < N; i++)
          setSprite(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 3) != 0, 12'($urandom));
        frameStart = 1'b1;
        pix(0, 0, 0, 0);
      end else begin
        frameStart = 1'b0;
        j = $urandom_range(0, N - 1);
        x = int'(spritePos[j*2*CW+CW +: CW]);
        y = int'(spritePos[j*2*CW +: CW]);
        pix((x + $urandom_range(0, 40) - 4) & 1023, (y - $urandom_range(0, 40) + 4) & 1023,
            $urandom_range(0, 7) != 0, $urandom_range(0, 4));
      end
      step();
      checks++;
      if (rgb !== rgbExp) $display("FAIL rand_rgb cyc=%0d got %h want %h", c, rgb, rgbExp);
      else passed++;
      checks++;
      if (collisionFlags !== flags)
        $display("FAIL rand_flags cyc=%0d got %b want %b", c, collisionFlags, flags);
      else passed++;
    end
    rst = 1'b0; frameStart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_collision();
    test_midframe();
    test_clip();
    test_rst_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
